// File: rtl/dds_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dds_ctrl_pkg
//   Constants shared by the DDS front-panel button controller.
//   - mode_e : encoding of the FreqPhaseSelect level (MODE_FREQ / MODE_PHASE)
//   - dir_e  : encoding of the UpDownSelect level
//   - DEFAULT_* : default parameter values for button_ctrl / button_debounce
// ---------------------------------------------------------------------------
package dds_ctrl_pkg;

    typedef enum logic {
        MODE_PHASE = 1'b0,
        MODE_FREQ  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int DEFAULT_DEBOUNCE_CYC = 500000;
    localparam int DEFAULT_DUTY_STEP    = 429496729;
    localparam int DEFAULT_REPEAT_DLY   = 25000000;
    localparam int DEFAULT_REPEAT_PER   = 5000000;

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//   Two-flop synchroniser plus counter debouncer for one active-low button.
//   The debounced level only follows the synchronised input after it has
//   disagreed for DEBOUNCE_CYC consecutive clocks; any agreeing sample
//   restarts the count.
//
//   Ports
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high
//     btn    : raw asynchronous button level (0 = pressed)
//     level  : debounced level (1 = released)
//     press  : one-clock pulse, registered together with a 1->0 level change
// ---------------------------------------------------------------------------
module button_debounce
    import dds_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             sync_lvl;

    assign sync_lvl = sync_reg[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg  <= 2'b11;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync_reg  <= {sync_reg[0], btn};
            press_reg <= 1'b0;
            if (sync_lvl == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // This is the DEBOUNCE_CYC-th disagreeing sample: accept it.
                cnt_reg   <= '0;
                level_reg <= sync_lvl;
                press_reg <= ~sync_lvl;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/button_ctrl.sv
// ---------------------------------------------------------------------------
// button_ctrl
//   Front-panel push-button controller for a DDS. Each button is synchronised
//   and debounced; a debounced press becomes a one-clock strobe (frequency
//   mode: per-digit up/down) or, in phase mode, a saturating PWM duty step
//   (button 0) or a phase up/down strobe (button 1).
//
//   Ports
//     clk             : system clock, rising edge
//     reset           : synchronous, active-high
//     FreqPhaseSelect : async level, 1 = frequency mode, 0 = phase/PWM mode
//     UpDownSelect    : async level, 1 = up, 0 = down
//     PushButton      : async, active-low, NUM_BTN buttons
//     freq_up_stb     : per-digit frequency up strobes (bit 0 = finest)
//     freq_dn_stb     : per-digit frequency down strobes
//     phase_up_stb    : phase up strobe
//     phase_dn_stb    : phase down strobe
//     PWMDuty         : registered duty word, resets to mid-scale
//
//   Build option: define BUTTON_AUTOREPEAT_EN to re-issue a held button's
//   event after REPEAT_DLY clocks and then every REPEAT_PER clocks.
// ---------------------------------------------------------------------------
module button_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int NUM_BTN      = 3,
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
    parameter int DUTY_W       = 32,
    parameter int DUTY_STEP    = DEFAULT_DUTY_STEP,
    parameter int REPEAT_DLY   = DEFAULT_REPEAT_DLY,
    parameter int REPEAT_PER   = DEFAULT_REPEAT_PER
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FreqPhaseSelect,
    input  logic               UpDownSelect,
    input  logic [NUM_BTN-1:0] PushButton,
    output logic [NUM_BTN-1:0] freq_up_stb,
    output logic [NUM_BTN-1:0] freq_dn_stb,
    output logic               phase_up_stb,
    output logic               phase_dn_stb,
    output logic [DUTY_W-1:0]  PWMDuty
);

    localparam int BTN_W = $clog2(NUM_BTN);
    localparam logic [DUTY_W-1:0] DUTY_INC = DUTY_W'(DUTY_STEP);
    localparam logic [DUTY_W-1:0] DUTY_MID = {1'b1, {(DUTY_W-1){1'b0}}};
    localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};

    // ------------------------------------------------------------------
    // Per-button synchroniser + debouncer
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] press_evt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .btn   (PushButton[gi]),
                .level (level_w[gi]),
                .press (press_w[gi])
            );
        end
    endgenerate

    // A press pulse always coincides with a low debounced level; qualifying
    // on it keeps the event definition self-evident at this level.
    assign press_evt = press_w & ~level_w;

    // ------------------------------------------------------------------
    // Select synchronisers (reset to 1, same latency as the buttons)
    // ------------------------------------------------------------------
    logic [1:0] mode_sync_reg;
    logic [1:0] dir_sync_reg;
    logic       mode_sel;
    logic       dir_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_sync_reg <= 2'b11;
            dir_sync_reg  <= 2'b11;
        end else begin
            mode_sync_reg <= {mode_sync_reg[0], FreqPhaseSelect};
            dir_sync_reg  <= {dir_sync_reg[0], UpDownSelect};
        end
    end

    assign mode_sel = mode_sync_reg[1];
    assign dir_sel  = dir_sync_reg[1];

    // ------------------------------------------------------------------
    // Lowest-index press wins; the rest are dropped
    // ------------------------------------------------------------------
    logic             win_valid;
    logic [BTN_W-1:0] win_btn;

    always_comb begin
        win_valid = 1'b0;
        win_btn   = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press_evt[i]) begin
                win_valid = 1'b1;
                win_btn   = BTN_W'(i);
            end
        end
    end

    logic             evt_valid;
    logic [BTN_W-1:0] evt_btn;

`ifdef BUTTON_AUTOREPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat for the most recent winning button. The counter restarts
    // at every press or repeat; the first interval is REPEAT_DLY, later
    // ones REPEAT_PER. A debounced release stops it.
    // ------------------------------------------------------------------
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RCNT_W  = $clog2(REP_MAX + 1);
    localparam logic [RCNT_W-1:0] REP_DLY_LAST = RCNT_W'(REPEAT_DLY - 1);
    localparam logic [RCNT_W-1:0] REP_PER_LAST = RCNT_W'(REPEAT_PER - 1);

    logic              rep_active_reg;
    logic              rep_first_reg;
    logic [RCNT_W-1:0] rep_cnt_reg;
    logic [BTN_W-1:0]  rep_btn_reg;
    logic              rep_held;
    logic              rep_fire;

    assign rep_held = ~level_w[rep_btn_reg];
    assign rep_fire = rep_active_reg && rep_held &&
                      (rep_cnt_reg == (rep_first_reg ? REP_DLY_LAST : REP_PER_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_active_reg <= 1'b0;
            rep_first_reg  <= 1'b0;
            rep_cnt_reg    <= '0;
            rep_btn_reg    <= '0;
        end else if (win_valid) begin
            rep_active_reg <= 1'b1;
            rep_first_reg  <= 1'b1;
            rep_cnt_reg    <= '0;
            rep_btn_reg    <= win_btn;
        end else if (rep_active_reg && !rep_held) begin
            rep_active_reg <= 1'b0;
        end else if (rep_fire) begin
            rep_first_reg <= 1'b0;
            rep_cnt_reg   <= '0;
        end else if (rep_active_reg) begin
            rep_cnt_reg <= rep_cnt_reg + 1'b1;
        end
    end

    // A fresh press takes precedence over a repeat falling in the same clock.
    assign evt_valid = win_valid | rep_fire;
    assign evt_btn   = win_valid ? win_btn : rep_btn_reg;
`else
    // Single event per press; repeat timing parameters have no effect.
    if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_repeat_cfg_unused
    end

    assign evt_valid = win_valid;
    assign evt_btn   = win_btn;
`endif

    // ------------------------------------------------------------------
    // Event decode and saturating duty arithmetic
    // ------------------------------------------------------------------
    logic [DUTY_W:0]    duty_sum;
    logic [DUTY_W-1:0]  duty_up;
    logic [DUTY_W-1:0]  duty_dn;

    logic [NUM_BTN-1:0] freq_up_reg,  freq_up_next;
    logic [NUM_BTN-1:0] freq_dn_reg,  freq_dn_next;
    logic               phase_up_reg, phase_up_next;
    logic               phase_dn_reg, phase_dn_next;
    logic [DUTY_W-1:0]  duty_reg,     duty_next;

    assign duty_sum = {1'b0, duty_reg} + {1'b0, DUTY_INC};
    assign duty_up  = duty_sum[DUTY_W] ? DUTY_MAX : duty_sum[DUTY_W-1:0];
    assign duty_dn  = (duty_reg < DUTY_INC) ? '0 : (duty_reg - DUTY_INC);

    always_comb begin
        freq_up_next  = '0;
        freq_dn_next  = '0;
        phase_up_next = 1'b0;
        phase_dn_next = 1'b0;
        duty_next     = duty_reg;
        if (evt_valid) begin
            if (mode_e'(mode_sel) == MODE_FREQ) begin
                if (dir_e'(dir_sel) == DIR_UP) begin
                    freq_up_next[evt_btn] = 1'b1;
                end else begin
                    freq_dn_next[evt_btn] = 1'b1;
                end
            end else if (evt_btn == BTN_W'(0)) begin
                duty_next = (dir_e'(dir_sel) == DIR_UP) ? duty_up : duty_dn;
            end else if (evt_btn == BTN_W'(1)) begin
                phase_up_next = (dir_e'(dir_sel) == DIR_UP);
                phase_dn_next = (dir_e'(dir_sel) == DIR_DOWN);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            freq_up_reg  <= '0;
            freq_dn_reg  <= '0;
            phase_up_reg <= 1'b0;
            phase_dn_reg <= 1'b0;
            duty_reg     <= DUTY_MID;
        end else begin
            freq_up_reg  <= freq_up_next;
            freq_dn_reg  <= freq_dn_next;
            phase_up_reg <= phase_up_next;
            phase_dn_reg <= phase_dn_next;
            duty_reg     <= duty_next;
        end
    end

    assign freq_up_stb  = freq_up_reg;
    assign freq_dn_stb  = freq_dn_reg;
    assign phase_up_stb = phase_up_reg;
    assign phase_dn_stb = phase_dn_reg;
    assign PWMDuty      = duty_reg;

endmodule
